// File: rtl/rect_motion_ctrl.sv
// Per-frame motion controller for one rectangle: integrates fixed-point position,
// applies gravity with speed saturation, and bounces off screen edges and collisions.
module rect_motion_ctrl #(
    parameter int INITIAL_X              = 280,
    parameter int INITIAL_Y              = 185,
    parameter int INITIAL_X_SPEED        = 64,
    parameter int INITIAL_Y_SPEED        = 0,
    parameter int Y_ACCEL                = 4,
    parameter int MAX_Y_SPEED            = 512,
    parameter int FIXED_POINT_MULTIPLIER = 64,
    parameter int OBJECT_WIDTH_X         = 32,
    parameter int OBJECT_HEIGHT_Y        = 16,
    parameter int SCREEN_W               = 640,
    parameter int SCREEN_H               = 480
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               collision,
    input  logic               toggleX,
    output logic signed [31:0] topLeftX,
    output logic signed [31:0] topLeftY,
    output logic               busy
);

    localparam int SHIFT = $clog2(FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] XLIM = 32'((SCREEN_W - OBJECT_WIDTH_X) * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] YLIM = 32'((SCREEN_H - OBJECT_HEIGHT_Y) * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] VMAX = 32'(MAX_Y_SPEED);

    typedef enum logic [1:0] {IDLE, MOVE, WALL, POSITION} state_t;

    state_t             state_q, state_d;
    logic signed [31:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
    logic signed [31:0] x_speed_q, x_speed_d, y_speed_q, y_speed_d;
    logic signed [31:0] top_x_q, top_x_d, top_y_q, top_y_d;
    logic               col_flag_q, col_flag_d, tog_flag_q, tog_flag_d;
    logic signed [31:0] ys_acc, xs_tog;
    logic               y_wall_hit;

    always_comb begin
        state_d    = state_q;
        x_pos_d    = x_pos_q;
        y_pos_d    = y_pos_q;
        x_speed_d  = x_speed_q;
        y_speed_d  = y_speed_q;
        top_x_d    = top_x_q;
        top_y_d    = top_y_q;
        ys_acc     = y_speed_q + 32'(Y_ACCEL);
        xs_tog     = tog_flag_q ? -x_speed_q : x_speed_q;
        y_wall_hit = 1'b0;

        // A new event in the clearing cycle must survive into the next frame.
        col_flag_d = (state_q == WALL) ? 1'b0 : col_flag_q;
        tog_flag_d = (state_q == WALL) ? 1'b0 : tog_flag_q;
        if (collision) col_flag_d = 1'b1;
        if (toggleX)   tog_flag_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (startOfFrame && enable) state_d = MOVE;
            end
            MOVE: begin
                x_pos_d = x_pos_q + x_speed_q;
                y_pos_d = y_pos_q + y_speed_q;
                if (ys_acc > VMAX)       y_speed_d = VMAX;
                else if (ys_acc < -VMAX) y_speed_d = -VMAX;
                else                     y_speed_d = ys_acc;
                state_d = WALL;
            end
            WALL: begin
                x_speed_d = xs_tog;
                if (x_pos_q < 0) begin
                    x_pos_d   = '0;
                    x_speed_d = (xs_tog < 0) ? -xs_tog : xs_tog;
                end else if (x_pos_q > XLIM) begin
                    x_pos_d   = XLIM;
                    x_speed_d = (xs_tog < 0) ? xs_tog : -xs_tog;
                end
                if (y_pos_q < 0) begin
                    y_wall_hit = 1'b1;
                    y_pos_d    = '0;
                    y_speed_d  = (y_speed_q < 0) ? -y_speed_q : y_speed_q;
                end else if (y_pos_q > YLIM) begin
                    y_wall_hit = 1'b1;
                    y_pos_d    = YLIM;
                    y_speed_d  = (y_speed_q < 0) ? y_speed_q : -y_speed_q;
                end
                if (col_flag_q && !y_wall_hit) y_speed_d = -y_speed_q;
                state_d = POSITION;
            end
            POSITION: begin
                top_x_d = x_pos_q >>> SHIFT;
                top_y_d = y_pos_q >>> SHIFT;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            x_pos_q    <= 32'(INITIAL_X * FIXED_POINT_MULTIPLIER);
            y_pos_q    <= 32'(INITIAL_Y * FIXED_POINT_MULTIPLIER);
            x_speed_q  <= 32'(INITIAL_X_SPEED);
            y_speed_q  <= 32'(INITIAL_Y_SPEED);
            top_x_q    <= 32'(INITIAL_X);
            top_y_q    <= 32'(INITIAL_Y);
            col_flag_q <= 1'b0;
            tog_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            x_speed_q  <= x_speed_d;
            y_speed_q  <= y_speed_d;
            top_x_q    <= top_x_d;
            top_y_q    <= top_y_d;
            col_flag_q <= col_flag_d;
            tog_flag_q <= tog_flag_d;
        end
    end

    assign topLeftX = top_x_q;
    assign topLeftY = top_y_q;
    assign busy     = (state_q != IDLE);

endmodule
